// File: rtl/bsg_thermometer_ramp.sv
// bsg_thermometer_ramp: binary target count in, registered thermometer mask out.
// The mask ramps toward each accepted target by at most step_p bits per cycle.
module bsg_thermometer_ramp #(
    parameter  int width_p      = 16,
    parameter  int step_p       = 1,
    localparam int cnt_width_lp = $clog2(width_p + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [cnt_width_lp-1:0] count_i,
    input  logic                    v_i,
    output logic                    ready_o,
    output logic [width_p-1:0]      o,
    output logic [cnt_width_lp-1:0] count_o,
    output logic                    busy_o,
    output logic                    done_o
);

    // One spare bit so differences and sums never wrap.
    localparam int ext_lp = cnt_width_lp + 1;

    typedef logic [ext_lp-1:0] ext_t;

    localparam ext_t width_lp = ext_t'(width_p);
    localparam ext_t step_lp  = ext_t'(step_p);

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_e;

    state_e                  r_state;
    state_e                  w_state_n;
    logic [cnt_width_lp-1:0] r_count;
    logic [cnt_width_lp-1:0] r_target;
    logic                    r_done;
    logic [width_p-1:0]      r_mask;

    logic                    w_ready;
    logic                    w_accept;
    ext_t                    w_req;
    ext_t                    w_clamp;
    ext_t                    w_tgt;
    ext_t                    w_cur;
    logic                    w_up;
    ext_t                    w_diff;
    ext_t                    w_step;
    logic                    w_move;
    ext_t                    w_next;
    logic                    w_done_n;
    logic [width_p-1:0]      w_mask_n;

    assign w_ready  = (r_state == IDLE) & ~reset_i;
    assign w_accept = v_i & w_ready;

    // Clamp the request before it can be latched as a target.
    assign w_req   = ext_t'(count_i);
    assign w_clamp = (w_req > width_lp) ? width_lp : w_req;

    // A fresh target is used on its accept edge so the first step costs no cycle.
    assign w_tgt = w_accept ? w_clamp : {1'b0, r_target};
    assign w_cur = {1'b0, r_count};

    assign w_up   = (w_tgt > w_cur);
    assign w_diff = w_up ? (w_tgt - w_cur) : (w_cur - w_tgt);
    assign w_step = (w_diff > step_lp) ? step_lp : w_diff;

    assign w_move = (r_state == RAMP) | (w_accept & (w_diff != '0));

    // Next count: limited step toward the target, never past it.
    always_comb begin
        w_next = w_cur;
        if (w_move) begin
            if (w_up) begin
                w_next = w_cur + w_step;
            end else begin
                w_next = w_cur - w_step;
            end
        end
    end

    // Next-state and done-pulse decision.
    always_comb begin
        w_state_n = r_state;
        w_done_n  = 1'b0;
        if (w_accept || (r_state == RAMP)) begin
            if (w_next == w_tgt) begin
                w_state_n = IDLE;
                w_done_n  = 1'b1;
            end else begin
                w_state_n = RAMP;
            end
        end
    end

    // Thermometer decode of the next count, registered below.
    always_comb begin
        w_mask_n = '0;
        for (int k = 0; k < width_p; k++) begin
            w_mask_n[k] = (k < int'(w_next));
        end
    end

    // State, count, mask and done registers; reset clears the mask at once.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_target <= '0;
            r_done   <= 1'b0;
            r_mask   <= '0;
        end else begin
            r_state <= w_state_n;
            r_count <= w_next[cnt_width_lp-1:0];
            r_done  <= w_done_n;
            r_mask  <= w_mask_n;
            if (w_accept) begin
                r_target <= w_clamp[cnt_width_lp-1:0];
            end
        end
    end

    assign ready_o = w_ready;
    assign o       = r_mask;
    assign count_o = r_count;
    assign busy_o  = (r_state == RAMP);
    assign done_o  = r_done;

endmodule
